// File: rtl/shunt_yard_engine.sv
// Infix-to-postfix (shunting-yard) engine: operator stack, per-opcode precedence/associativity.
// Optional macro SHUNT_PREC_CFG_EN adds a runtime-writable precedence table (cfg_* ports).
module shunt_yard_engine #(
  parameter int CO_N   = 4,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int PREC_W = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_is_op,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_is_op,
  output logic [DATA_W-1:0]        out_data,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   depth
`ifdef SHUNT_PREC_CFG_EN
  ,
  input  logic                     cfg_we,
  input  logic [CO_N-1:0]          cfg_op,
  input  logic [PREC_W-1:0]        cfg_prec,
  input  logic                     cfg_rassoc
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int NOPS = 2 ** CO_N;
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] IDX_ONE  = AW'(1);

  // Operator codes shared with the lexer and evaluator
  localparam logic [CO_N-1:0] CO_OK = CO_N'(0);
  localparam logic [CO_N-1:0] CO_AD = CO_N'(1);
  localparam logic [CO_N-1:0] CO_SB = CO_N'(2);
  localparam logic [CO_N-1:0] CO_AN = CO_N'(3);
  localparam logic [CO_N-1:0] CO_OR = CO_N'(4);
  localparam logic [CO_N-1:0] CO_LS = CO_N'(5);
  localparam logic [CO_N-1:0] CO_PS = CO_N'(6);
  localparam logic [CO_N-1:0] CO_NS = CO_N'(7);
  localparam logic [CO_N-1:0] CO_LP = CO_N'(8);
  localparam logic [CO_N-1:0] CO_RP = CO_N'(9);

  typedef enum logic [2:0] {IDLE, POP, UNWIND, FLUSH, ERR} state_t;

  function automatic logic [PREC_W-1:0] def_prec(input logic [CO_N-1:0] op);
    case (op)
      CO_AD, CO_SB: def_prec = PREC_W'(1);
      CO_AN, CO_OR: def_prec = PREC_W'(2);
      CO_LS:        def_prec = PREC_W'(3);
      CO_PS, CO_NS: def_prec = PREC_W'(4);
      default:      def_prec = '0;
    endcase
  endfunction

  function automatic logic def_rassoc(input logic [CO_N-1:0] op);
    def_rassoc = (op == CO_PS) || (op == CO_NS);
  endfunction

  state_t                state_q, state_d;
  logic [AW:0]           depth_q, depth_d;
  logic [CO_N-1:0]       pend_q, pend_d;
  logic                  err_q, err_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_is_op_q, out_is_op_d;
  logic [DATA_W-1:0]     out_data_q, out_data_d;
  logic [CO_N-1:0]       stack_q [DEPTH];
  logic [PREC_W-1:0]     prec_tbl [NOPS];
  logic                  rassoc_tbl [NOPS];

  logic                  slot_free;
  logic [AW-1:0]         top_idx;
  logic [CO_N-1:0]       top_op;
  logic [CO_N-1:0]       in_op;
  logic                  pop_ok;
  logic                  push;
  logic                  wr_en;
  logic [CO_N-1:0]       push_op;

`ifdef SHUNT_PREC_CFG_EN
  logic [PREC_W-1:0]     prec_q [NOPS];
  logic                  rassoc_q [NOPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NOPS; i++) begin
        prec_q[i]   <= def_prec(CO_N'(i));
        rassoc_q[i] <= def_rassoc(CO_N'(i));
      end
    end else if (cfg_we && state_q == IDLE) begin
      prec_q[cfg_op]   <= cfg_prec;
      rassoc_q[cfg_op] <= cfg_rassoc;
    end
  end

  always_comb begin
    for (int i = 0; i < NOPS; i++) begin
      prec_tbl[i]   = prec_q[i];
      rassoc_tbl[i] = rassoc_q[i];
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NOPS; i++) begin
      prec_tbl[i]   = def_prec(CO_N'(i));
      rassoc_tbl[i] = def_rassoc(CO_N'(i));
    end
  end
`endif

  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = rst_n && (state_q == IDLE) && slot_free;
  assign top_idx   = depth_q[AW-1:0] - IDX_ONE;
  assign top_op    = stack_q[top_idx];
  assign in_op     = in_data[CO_N-1:0];

  // Equal precedence pops only when the incoming operator is left-associative
  assign pop_ok = (depth_q != '0) && (top_op != CO_LP) &&
                  ((prec_tbl[top_op] > prec_tbl[pend_q]) ||
                   ((prec_tbl[top_op] == prec_tbl[pend_q]) && !rassoc_tbl[pend_q]));

  always_comb begin
    state_d     = state_q;
    depth_d     = depth_q;
    pend_d      = pend_q;
    err_d       = err_q;
    out_valid_d = out_valid_q && !out_ready;
    out_is_op_d = out_is_op_q;
    out_data_d  = out_data_q;
    push        = 1'b0;
    push_op     = pend_q;
    wr_en       = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          if (!in_is_op) begin
            out_valid_d = 1'b1;
            out_is_op_d = 1'b0;
            out_data_d  = in_data;
          end else if (in_op == CO_LP) begin
            push    = 1'b1;
            push_op = CO_LP;
          end else if (in_op == CO_RP) begin
            state_d = UNWIND;
          end else if (in_op == CO_OK) begin
            state_d = FLUSH;
          end else begin
            pend_d  = in_op;
            state_d = POP;
          end
        end
      end
      POP: begin
        if (pop_ok) begin
          if (slot_free) begin
            out_valid_d = 1'b1;
            out_is_op_d = 1'b1;
            out_data_d  = DATA_W'(top_op);
            depth_d     = depth_q - CNT_ONE;
          end
        end else begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      UNWIND: begin
        if (depth_q == '0) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else if (top_op == CO_LP) begin
          depth_d = depth_q - CNT_ONE;
          state_d = IDLE;
        end else if (slot_free) begin
          out_valid_d = 1'b1;
          out_is_op_d = 1'b1;
          out_data_d  = DATA_W'(top_op);
          depth_d     = depth_q - CNT_ONE;
        end
      end
      FLUSH: begin
        if (depth_q == '0) begin
          if (slot_free) begin
            out_valid_d = 1'b1;
            out_is_op_d = 1'b1;
            out_data_d  = DATA_W'(CO_OK);
            state_d     = IDLE;
          end
        end else if (top_op == CO_LP) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else if (slot_free) begin
          out_valid_d = 1'b1;
          out_is_op_d = 1'b1;
          out_data_d  = DATA_W'(top_op);
          depth_d     = depth_q - CNT_ONE;
        end
      end
      default: ;
    endcase

    if (push) begin
      if (depth_q == FULL_CNT) begin
        err_d   = 1'b1;
        state_d = ERR;
      end else begin
        wr_en   = 1'b1;
        depth_d = depth_q + CNT_ONE;
      end
    end

    if (clr) begin
      state_d     = IDLE;
      depth_d     = '0;
      err_d       = 1'b0;
      out_valid_d = 1'b0;
      wr_en       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      depth_q     <= '0;
      pend_q      <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_is_op_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      pend_q      <= pend_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_is_op_q <= out_is_op_d;
      out_data_q  <= out_data_d;
    end
  end

  // Stack storage needs no reset: occupancy alone decides which entries are live
  always_ff @(posedge clk) begin
    if (wr_en) stack_q[depth_q[AW-1:0]] <= push_op;
  end

  assign out_valid = out_valid_q;
  assign out_is_op = out_is_op_q;
  assign out_data  = out_data_q;
  assign err       = err_q;
  assign depth     = depth_q;

endmodule

// File: tb/tb_shunt_yard_engine.sv
// Bench for shunt_yard_engine (DEPTH=4): table-driven RPN vectors plus error, backpressure and reset sequences.
module tb_shunt_yard_engine;

  localparam int DW = 16;
  localparam logic [3:0] OK = 4'd0, AD = 4'd1, SB = 4'd2, AN = 4'd3, OR = 4'd4,
                         LS = 4'd5, PS = 4'd6, NS = 4'd7, LP = 4'd8, RP = 4'd9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_is_op = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b1;
  logic          in_ready, out_valid, out_is_op, err;
  logic [DW-1:0] out_data;
  logic [2:0]    depth;

  shunt_yard_engine #(.CO_N(4), .DATA_W(DW), .DEPTH(4), .PREC_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_op(in_is_op), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_is_op(out_is_op), .out_data(out_data),
    .err(err), .depth(depth)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [4:0] sb_q[$];

  typedef struct packed {
    int               ntok;
    logic [7:0][4:0]  tok;
    int               nexp;
    logic [7:0][4:0]  exp;
  } vec_t;
  vec_t vecs[6];

  function automatic logic [4:0] op(input logic [3:0] c);
    return {1'b1, c};
  endfunction
  function automatic logic [4:0] num(input logic [3:0] v);
    return {1'b0, v};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, expv);
    end
  endtask

  task automatic monitor();
    logic [4:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got op=%0b data=%0h, required no token", out_is_op, out_data);
        end else begin
          e = sb_q.pop_front();
          chk("rpn_token", 32'({out_is_op, out_data}), 32'({e[4], 12'h000, e[3:0]}));
        end
      end
    end
  endtask

  task automatic send(input logic [4:0] t);
    int n = 0;
    in_valid = 1'b1;
    in_is_op = t[4];
    in_data  = {12'h000, t[3:0]};
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%0b, required 1 within 50 cycles", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk({name, "_pending"}, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic run_vec(input int v);
    for (int i = 0; i < vecs[v].nexp; i++) sb_q.push_back(vecs[v].exp[vecs[v].nexp - 1 - i]);
    for (int i = 0; i < vecs[v].ntok; i++) send(vecs[v].tok[vecs[v].ntok - 1 - i]);
    drain("vec");
    repeat (3) @(posedge clk);
    #1;
    chk("vec_err", 32'(err), 32'd0);
    chk("vec_depth", 32'(depth), 32'd0);
    chk("vec_idle_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    // Tokens and expected RPN listed in natural order (first element first)
    vecs[0].ntok = 6; vecs[0].tok = 40'({num(2), op(AD), num(3), op(LS), num(4), op(OK)});
    vecs[0].nexp = 6; vecs[0].exp = 40'({num(2), num(3), num(4), op(LS), op(AD), op(OK)});
    vecs[1].ntok = 8; vecs[1].tok = 40'({op(LP), num(2), op(AD), num(3), op(RP), op(LS), num(4), op(OK)});
    vecs[1].nexp = 6; vecs[1].exp = 40'({num(2), num(3), op(AD), num(4), op(LS), op(OK)});
    vecs[2].ntok = 6; vecs[2].tok = 40'({num(5), op(SB), num(1), op(SB), num(1), op(OK)});
    vecs[2].nexp = 6; vecs[2].exp = 40'({num(5), num(1), op(SB), num(1), op(SB), op(OK)});
    vecs[3].ntok = 4; vecs[3].tok = 40'({op(PS), op(PS), num(7), op(OK)});
    vecs[3].nexp = 4; vecs[3].exp = 40'({num(7), op(PS), op(PS), op(OK)});
    vecs[4].ntok = 8; vecs[4].tok = 40'({num(1), op(AN), num(2), op(OR), num(3), op(AD), num(4), op(OK)});
    vecs[4].nexp = 8; vecs[4].exp = 40'({num(1), num(2), op(AN), num(3), op(OR), num(4), op(AD), op(OK)});
    vecs[5].ntok = 5; vecs[5].tok = 40'({op(NS), num(2), op(LS), num(3), op(OK)});
    vecs[5].nexp = 5; vecs[5].exp = 40'({num(2), op(NS), num(3), op(LS), op(OK)});

    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    for (int v = 0; v < 6; v++) run_vec(v);

    // Unbalanced RP on empty stack
    sb_q.push_back(num(2));
    send(num(2));
    send(op(RP));
    repeat (2) @(posedge clk);
    #1;
    chk("rp_err", 32'(err), 32'd1);
    chk("rp_in_ready", 32'(in_ready), 32'd0);
    drain("rp");
    pulse_clr();
    chk("clr_err", 32'(err), 32'd0);
    chk("clr_depth", 32'(depth), 32'd0);
    chk("clr_in_ready", 32'(in_ready), 32'd1);

    // LP left on the stack at flush
    sb_q.push_back(num(2));
    send(op(LP));
    send(num(2));
    send(op(OK));
    drain("lp_ok");
    repeat (2) @(posedge clk);
    #1;
    chk("lp_ok_err", 32'(err), 32'd1);
    chk("lp_ok_out_valid", 32'(out_valid), 32'd0);
    chk("lp_ok_depth", 32'(depth), 32'd1);
    pulse_clr();

    // Overflow: fifth push into a 4-deep stack
    repeat (4) send(op(LP));
    chk("full_depth", 32'(depth), 32'd4);
    chk("full_err", 32'(err), 32'd0);
    send(op(LP));
    repeat (2) @(posedge clk);
    #1;
    chk("ovf_err", 32'(err), 32'd1);
    chk("ovf_depth", 32'(depth), 32'd4);
    chk("ovf_in_ready", 32'(in_ready), 32'd0);
    pulse_clr();
    chk("ovf_clr_depth", 32'(depth), 32'd0);

    // Backpressure during flush
    sb_q.push_back(num(7));
    sb_q.push_back(op(PS));
    sb_q.push_back(op(PS));
    sb_q.push_back(op(PS));
    sb_q.push_back(op(OK));
    repeat (3) send(op(PS));
    send(num(7));
    send(op(OK));
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'({out_is_op, out_data}), 32'({1'b1, 12'h000, PS}));
      chk("bp_depth", 32'(depth), 32'd2);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    drain("bp");
    repeat (2) @(posedge clk);
    #1;
    chk("bp_end_depth", 32'(depth), 32'd0);
    chk("bp_end_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset while stalled in POP
    sb_q.push_back(num(1));
    sb_q.push_back(num(2));
    sb_q.push_back(num(3));
    send(num(1));
    send(op(AN));
    send(num(2));
    send(op(LS));
    send(num(3));
    send(op(AD));
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("stall_out_data", 32'({out_is_op, out_data}), 32'({1'b1, 12'h000, LS}));
    chk("stall_depth", 32'(depth), 32'd1);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_is_op", 32'(out_is_op), 32'd0);
    chk("arst_out_data", 32'(out_data), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_depth", 32'(depth), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    chk("arst_sb_before", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_release_ready", 32'(in_ready), 32'd1);
    run_vec(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
